// File: rtl/wb_pkg.sv
// Shared definitions for the write-back/commit stage.
// Opcode values and FSM state encoding.
package wb_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_MUL   = 5'b00011;
  localparam logic [4:0] OP_STORE = 5'b01100;
  localparam logic [4:0] OP_JMP   = 5'b01101;
  localparam logic [4:0] OP_BEQZ  = 5'b01110;
  localparam logic [4:0] OP_BCAR  = 5'b10110;
  localparam logic [4:0] OP_BAUX  = 5'b10111;
  localparam logic [4:0] OP_BPAR  = 5'b11000;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL_HI = 2'd1,
    ST_HALT   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_decode.sv
// Opcode class decoder for the write-back stage.
// Purely combinational: opcode, am and flags to write classes.
module wb_decode
  import wb_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic       am,
  input  logic       zero_flag,
  input  logic       carry_flag,
  input  logic       auxiliary_flag,
  input  logic       parity_flag,
  output logic       is_mul,
  output logic       wr_rf,
  output logic       wr_mem,
  output logic       br_taken,
  output logic       is_halt
);

  always_comb begin
    is_mul   = 1'b0;
    wr_rf    = 1'b0;
    wr_mem   = 1'b0;
    br_taken = 1'b0;
    is_halt  = 1'b0;
    unique case (1'b1)
      (opcode == OP_NOP): ;
      (opcode == OP_MUL): begin
        is_mul = 1'b1;
        wr_rf  = !am;
        wr_mem = am;
      end
      (opcode == OP_STORE): wr_mem = 1'b1;
      (opcode == OP_JMP):   br_taken = 1'b1;
      (opcode == OP_BEQZ):  br_taken = zero_flag;
      (opcode == OP_BCAR):  br_taken = carry_flag;
      (opcode == OP_BAUX):  br_taken = auxiliary_flag;
      (opcode == OP_BPAR):  br_taken = parity_flag;
      (opcode == OP_HALT):  is_halt = 1'b1;
      default: begin
        wr_rf  = !am;
        wr_mem = am;
      end
    endcase
  end

endmodule

// File: rtl/write_back_unit.sv
// Write-back/commit stage: registered rf/mem/pc strobes,
// two-cycle MUL write-back, branch flush and sticky halt.
module write_back_unit
  import wb_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int NREGS     = 8,
  parameter  int MEM_DEPTH = 16,
  parameter  int PC_W      = 6,
  localparam int RA_W      = $clog2(NREGS),
  localparam int MA_W      = $clog2(MEM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          opcode,
  input  logic                am,
  input  logic [RA_W-1:0]     rd,
  input  logic [MA_W-1:0]     mem_addr,
  input  logic [PC_W-1:0]     target_addr,
  input  logic [2*DATA_W-1:0] alu_out,
  input  logic                zero_flag,
  input  logic                carry_flag,
  input  logic                auxiliary_flag,
  input  logic                parity_flag,
  output logic                rf_we,
  output logic [RA_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                mem_we,
  output logic [MA_W-1:0]     mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                pc_load,
  output logic [PC_W-1:0]     pc_target,
  output logic                flush,
  output logic                halted
);

  wb_state_t state, state_n;

  logic is_mul, wr_rf, wr_mem, br_taken, is_halt;
  logic accept;

  logic [DATA_W-1:0] hi_word;
  logic              hi_am;
  logic [RA_W-1:0]   hi_rd;
  logic [MA_W-1:0]   hi_ma;

  wb_decode u_dec (
    .opcode         (opcode),
    .am             (am),
    .zero_flag      (zero_flag),
    .carry_flag     (carry_flag),
    .auxiliary_flag (auxiliary_flag),
    .parity_flag    (parity_flag),
    .is_mul         (is_mul),
    .wr_rf          (wr_rf),
    .wr_mem         (wr_mem),
    .br_taken       (br_taken),
    .is_halt        (is_halt)
  );

  assign in_ready = (state == ST_IDLE);
  assign halted   = (state == ST_HALT);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (accept && is_halt)     state_n = ST_HALT;
        else if (accept && is_mul) state_n = ST_MUL_HI;
      end
      ST_MUL_HI: state_n = ST_IDLE;
      ST_HALT:   state_n = ST_HALT;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      flush     <= 1'b0;
      hi_word   <= '0;
      hi_am     <= 1'b0;
      hi_rd     <= '0;
      hi_ma     <= '0;
    end else begin
      rf_we   <= 1'b0;
      mem_we  <= 1'b0;
      pc_load <= 1'b0;
      flush   <= 1'b0;
      if (state == ST_MUL_HI) begin
        if (hi_am) begin
          mem_we    <= 1'b1;
          mem_waddr <= hi_ma;
          mem_wdata <= hi_word;
        end else begin
          rf_we    <= 1'b1;
          rf_waddr <= hi_rd;
          rf_wdata <= hi_word;
        end
      end else if (accept) begin
        if (wr_rf) begin
          rf_we    <= 1'b1;
          rf_waddr <= rd;
          rf_wdata <= alu_out[DATA_W-1:0];
        end
        if (wr_mem) begin
          mem_we    <= 1'b1;
          mem_waddr <= mem_addr;
          mem_wdata <= alu_out[DATA_W-1:0];
        end
        if (br_taken) begin
          pc_load   <= 1'b1;
          flush     <= 1'b1;
          pc_target <= target_addr;
        end
        // address+1 wraps by plain width overflow
        if (is_mul) begin
          hi_word <= alu_out[2*DATA_W-1:DATA_W];
          hi_am   <= am;
          hi_rd   <= rd + RA_W'(1);
          hi_ma   <= mem_addr + MA_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_write_back_unit.sv
// Bench for write_back_unit: directed vector table followed by
// random traffic compared against a behavioural model.
module tb_write_back_unit;

  localparam logic [4:0] NOP  = 5'd0;
  localparam logic [4:0] ADD  = 5'd1;
  localparam logic [4:0] MUL  = 5'd3;
  localparam logic [4:0] INC  = 5'd5;
  localparam logic [4:0] STO  = 5'd12;
  localparam logic [4:0] JMP  = 5'd13;
  localparam logic [4:0] BEQZ = 5'd14;
  localparam logic [4:0] BCAR = 5'd22;
  localparam logic [4:0] BAUX = 5'd23;
  localparam logic [4:0] BPAR = 5'd24;
  localparam logic [4:0] HLT  = 5'd31;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [4:0]  op;
    logic        am;
    logic [2:0]  rd;
    logic [3:0]  ma;
    logic [5:0]  tgt;
    logic [15:0] alu;
    logic [3:0]  flg;
  } vin_t;

  typedef struct packed {
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       pc_load;
    logic [5:0] pc_target;
    logic       flush;
    logic       halted;
    logic       ready;
  } obs_t;

  typedef struct {
    vin_t i;
    obs_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic        am;
  logic [2:0]  rd;
  logic [3:0]  mem_addr;
  logic [5:0]  target_addr;
  logic [15:0] alu_out;
  logic        zero_flag, carry_flag, auxiliary_flag, parity_flag;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic        mem_we;
  logic [3:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic        pc_load;
  logic [5:0]  pc_target;
  logic        flush;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  write_back_unit dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .opcode         (opcode),
    .am             (am),
    .rd             (rd),
    .mem_addr       (mem_addr),
    .target_addr    (target_addr),
    .alu_out        (alu_out),
    .zero_flag      (zero_flag),
    .carry_flag     (carry_flag),
    .auxiliary_flag (auxiliary_flag),
    .parity_flag    (parity_flag),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .mem_we         (mem_we),
    .mem_waddr      (mem_waddr),
    .mem_wdata      (mem_wdata),
    .pc_load        (pc_load),
    .pc_target      (pc_target),
    .flush          (flush),
    .halted         (halted)
  );

  function automatic vin_t vi(bit r, bit v, logic [4:0] op, bit a,
                              int d, int m, int t, int alu,
                              logic [3:0] f);
    vin_t x;
    x.rst = r; x.valid = v; x.op = op; x.am = a;
    x.rd = 3'(d); x.ma = 4'(m); x.tgt = 6'(t);
    x.alu = 16'(alu); x.flg = f;
    return x;
  endfunction

  function automatic obs_t ob(bit rw, int ra, int rdat, bit mw,
                              int ma, int md, bit pl, int pt,
                              bit fl, bit h, bit rdy);
    obs_t x;
    x.rf_we = rw; x.rf_waddr = 3'(ra); x.rf_wdata = 8'(rdat);
    x.mem_we = mw; x.mem_waddr = 4'(ma); x.mem_wdata = 8'(md);
    x.pc_load = pl; x.pc_target = 6'(pt); x.flush = fl;
    x.halted = h; x.ready = rdy;
    return x;
  endfunction

  task automatic drive(input vin_t v);
    @(negedge clk);
    rst            = v.rst;
    in_valid       = v.valid;
    opcode         = v.op;
    am             = v.am;
    rd             = v.rd;
    mem_addr       = v.ma;
    target_addr    = v.tgt;
    alu_out        = v.alu;
    zero_flag      = v.flg[3];
    carry_flag     = v.flg[2];
    auxiliary_flag = v.flg[1];
    parity_flag    = v.flg[0];
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t got;
    got = {rf_we, rf_waddr, rf_wdata, mem_we, mem_waddr,
           mem_wdata, pc_load, pc_target, flush, halted, in_ready};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // behavioural reference for the random phase
  obs_t e;
  bit   m_halt;
  bit   m_pend;
  bit   m_pmem;
  int   m_paddr;
  logic [7:0] m_pdata;

  task automatic put(input bit to_mem, input int addr, input logic [7:0] d);
    if (to_mem) begin
      e.mem_we = 1; e.mem_waddr = 4'(addr); e.mem_wdata = d;
    end else begin
      e.rf_we = 1; e.rf_waddr = 3'(addr); e.rf_wdata = d;
    end
  endtask

  task automatic take(input bit cond, input logic [5:0] t);
    if (cond) begin
      e.pc_load = 1; e.flush = 1; e.pc_target = t;
    end
  endtask

  task automatic model(input vin_t v);
    if (v.rst) begin
      e = '0;
      e.ready = 1;
      m_halt = 0;
      m_pend = 0;
      return;
    end
    e.rf_we = 0; e.mem_we = 0; e.pc_load = 0; e.flush = 0;
    if (m_pend) begin
      m_pend = 0;
      put(m_pmem, m_paddr, m_pdata);
    end else if (!m_halt && v.valid) begin
      case (v.op)
        NOP: ;
        MUL: begin
          put(v.am, v.am ? int'(v.ma) : int'(v.rd), v.alu[7:0]);
          m_pend  = 1;
          m_pmem  = v.am;
          m_paddr = v.am ? (int'(v.ma) + 1) % 16 : (int'(v.rd) + 1) % 8;
          m_pdata = v.alu[15:8];
        end
        STO:  put(1, int'(v.ma), v.alu[7:0]);
        JMP:  take(1, v.tgt);
        BEQZ: take(v.flg[3], v.tgt);
        BCAR: take(v.flg[2], v.tgt);
        BAUX: take(v.flg[1], v.tgt);
        BPAR: take(v.flg[0], v.tgt);
        HLT:  m_halt = 1;
        default: put(v.am, v.am ? int'(v.ma) : int'(v.rd), v.alu[7:0]);
      endcase
    end
    e.halted = m_halt;
    e.ready  = !m_halt && !m_pend;
  endtask

  vec_t tv[21];
  logic [4:0] pick[11];

  initial begin
    tv[0]  = '{vi(1,0,NOP,0,0,0,0,0,0),         ob(0,0,0,0,0,0,0,0,0,0,1)};
    tv[1]  = '{vi(0,1,ADD,0,1,0,0,'h00C0,0),    ob(1,1,'hC0,0,0,0,0,0,0,0,1)};
    tv[2]  = '{vi(0,1,INC,1,0,0,0,'h0003,0),    ob(0,1,'hC0,1,0,'h03,0,0,0,0,1)};
    tv[3]  = '{vi(0,1,STO,0,5,2,0,'h0040,0),    ob(0,1,'hC0,1,2,'h40,0,0,0,0,1)};
    tv[4]  = '{vi(0,1,MUL,0,7,0,0,'hFE40,0),    ob(1,7,'h40,0,2,'h40,0,0,0,0,0)};
    tv[5]  = '{vi(0,1,ADD,0,3,0,0,'h0011,0),    ob(1,0,'hFE,0,2,'h40,0,0,0,0,1)};
    tv[6]  = '{vi(0,1,ADD,0,3,0,0,'h0011,0),    ob(1,3,'h11,0,2,'h40,0,0,0,0,1)};
    tv[7]  = '{vi(0,1,BEQZ,0,0,0,4,0,4'b0000),  ob(0,3,'h11,0,2,'h40,0,0,0,0,1)};
    tv[8]  = '{vi(0,1,BEQZ,0,0,0,4,0,4'b1000),  ob(0,3,'h11,0,2,'h40,1,4,1,0,1)};
    tv[9]  = '{vi(0,1,BPAR,0,0,0,5,0,4'b1110),  ob(0,3,'h11,0,2,'h40,0,4,0,0,1)};
    tv[10] = '{vi(0,1,BPAR,0,0,0,5,0,4'b0001),  ob(0,3,'h11,0,2,'h40,1,5,1,0,1)};
    tv[11] = '{vi(0,0,ADD,0,6,0,0,'h0099,0),    ob(0,3,'h11,0,2,'h40,0,5,0,0,1)};
    tv[12] = '{vi(0,1,MUL,1,0,15,0,'h1234,0),   ob(0,3,'h11,1,15,'h34,0,5,0,0,0)};
    tv[13] = '{vi(0,0,NOP,0,0,0,0,0,0),         ob(0,3,'h11,1,0,'h12,0,5,0,0,1)};
    tv[14] = '{vi(0,1,HLT,0,0,0,0,0,0),         ob(0,3,'h11,0,0,'h12,0,5,0,1,0)};
    tv[15] = '{vi(0,1,ADD,0,2,0,0,'h0055,0),    ob(0,3,'h11,0,0,'h12,0,5,0,1,0)};
    tv[16] = '{vi(1,1,ADD,0,2,0,0,'h0055,0),    ob(0,0,0,0,0,0,0,0,0,0,1)};
    tv[17] = '{vi(0,1,MUL,0,7,0,0,'hAB09,0),    ob(1,7,'h09,0,0,0,0,0,0,0,0)};
    tv[18] = '{vi(1,1,ADD,0,2,0,0,'h0055,0),    ob(0,0,0,0,0,0,0,0,0,0,1)};
    tv[19] = '{vi(0,0,NOP,0,0,0,0,0,0),         ob(0,0,0,0,0,0,0,0,0,0,1)};
    tv[20] = '{vi(0,1,JMP,0,0,0,'h3F,0,0),      ob(0,0,0,0,0,0,1,'h3F,1,0,1)};

    pick = '{NOP, ADD, MUL, INC, STO, JMP, BEQZ, BCAR, BAUX, BPAR, HLT};

    for (int i = 0; i < 21; i++) begin
      drive(tv[i].i);
      check($sformatf("vec%0d", i), tv[i].o);
    end

    e = '0;
    m_halt = 0;
    m_pend = 0;
    m_pmem = 0;
    m_paddr = 0;
    m_pdata = '0;
    for (int i = 0; i < 3000; i++) begin
      vin_t v;
      v.rst   = (i == 0) || ($urandom_range(0, 39) == 0);
      v.valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        v.op = pick[$urandom_range(0, 10)];
      else
        v.op = 5'($urandom_range(0, 31));
      v.am  = 1'($urandom_range(0, 1));
      v.rd  = 3'($urandom_range(0, 7));
      v.ma  = 4'($urandom_range(0, 15));
      v.tgt = 6'($urandom_range(0, 63));
      v.alu = 16'($urandom_range(0, 65535));
      v.flg = 4'($urandom_range(0, 15));
      model(v);
      drive(v);
      check($sformatf("rand%0d", i), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/write_back_unit.md
# write_back_unit

Parametrised write-back/commit stage for the microprocessor pipeline. It accepts one executed instruction per handshake and turns it into registered write strobes toward the register file, the data memory and the program counter. It extends the single-cycle write-back stage in three ways: widths and depths are generic, full-width MUL results are written back over two cycles, and taken branches raise a one-cycle pipeline flush. HALT is a sticky commit state.

## Interface
Parameters:
- DATA_W, 8, datapath width; alu_out is 2*DATA_W.
- NREGS, 8, register count; RA_W = clog2(NREGS).
- MEM_DEPTH, 16, data-memory words; MA_W = clog2(MEM_DEPTH).
- PC_W, 6, instruction-address width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the upstream instruction is valid.
- in_ready  out  1  the unit can accept; combinational from state.
- opcode  in  5  instruction opcode.
- am  in  1  addressing mode; 1 sends the result to memory instead of rd.
- rd  in  RA_W  destination register.
- mem_addr  in  MA_W  destination memory address.
- target_addr  in  PC_W  branch/jump target.
- alu_out  in  2*DATA_W  result; the low half is the normal result, the high half is the MUL upper word.
- zero_flag, carry_flag, auxiliary_flag, parity_flag  in  1 each  ALU flags.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  RA_W  register write address.
- rf_wdata  out  DATA_W  register write data.
- mem_we  out  1  memory write strobe.
- mem_waddr  out  MA_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- pc_load  out  1  load pc_target into the PC.
- pc_target  out  PC_W  new PC value.
- flush  out  1  squash younger in-flight instructions.
- halted  out  1  sticky halt indicator.

## Operation
- A transaction is accepted when in_valid && in_ready at a clock edge. All inputs, including the flags, are sampled at that edge.
- Opcode classes:
  - NOP 00000: no write.
  - MUL 00011: two-cycle write.
  - STORE 01100: memory write of alu_out[DATA_W-1:0] to mem_addr, regardless of am.
  - JMP 01101: unconditional load.
  - BEQZ 01110: branch if zero_flag.
  - BCAR 10110: branch if carry_flag.
  - BAUX 10111: branch if auxiliary_flag.
  - BPAR 11000: branch if parity_flag.
  - HALT 11111.
  - All other opcodes are ALU class: low half to rd when am=0, to mem_addr when am=1.
- Jump/branch:
  - Taken: pc_load=1, flush=1, pc_target=target_addr for one cycle.
  - Not taken: no strobe at all.
  - Jumps and branches never write the register file or memory.
- MUL:
  - Cycle 1 writes the low half to rd (am=0) or mem_addr (am=1).
  - Cycle 2 writes the high half to rd+1 mod NREGS or mem_addr+1 mod MEM_DEPTH. The wrap is natural RA_W/MA_W overflow.
- FSM states: IDLE, MUL_HI, HALT.
  - IDLE to MUL_HI on accepting MUL.
  - MUL_HI to IDLE unconditionally after one cycle.
  - IDLE to HALT on accepting HALT.
  - HALT is left only by rst.
- in_ready = (state==IDLE).
- In HALT, in_valid is ignored and every strobe stays 0.

## Timing
- Reset values: every strobe is 0, all address/data outputs are 0, halted=0, state=IDLE. in_ready is therefore 1 in the first cycle after reset.
- Latency: strobes for an instruction accepted at edge N are asserted in cycle N..N+1. They are registered and last exactly one cycle.
- MUL accepted at edge N:
  - Low write in cycle N..N+1, with in_ready=0.
  - High write in cycle N+1..N+2, with in_ready=1.
  - A new instruction accepted at edge N+2 has its strobes in N+2..N+3. There is no bubble beyond the single stall.
- HALT accepted at edge N: halted=1 from N onward; no strobes.
- Back-to-back non-MUL instructions run at full throughput, one per cycle.
- rst during MUL_HI aborts the high write. Outputs take their reset values at that edge.
- rst has priority over a simultaneous accept.
- With in_valid=0 in IDLE, strobes drop to 0 on the next edge. Address/data outputs hold their last values.

## Structure
- Shared package wb_pkg holds:
  - opcode localparams (OP_NOP, OP_MUL, OP_STORE, OP_JMP, OP_BEQZ, OP_BCAR, OP_BAUX, OP_BPAR, OP_HALT);
  - the state encoding (ST_IDLE, ST_MUL_HI, ST_HALT).
- One combinational sub-module, wb_decode: maps opcode, am and the flags to the class signals is_mul, wr_rf, wr_mem, br_taken and is_halt.
- write_back_unit holds the FSM, the output registers and a saved high word and address for MUL_HI.

## Test plan
- Reset, then ADD (00001), am=0, rd=1, alu_out=0x00C0 -> one cycle of rf_we=1, rf_waddr=1, rf_wdata=0xC0; mem_we=0.
- INC (00101), am=1, mem_addr=0, alu_out=0x0003, then STORE, mem_addr=2, alu_out=0x0040, back-to-back -> mem_we on two consecutive cycles, writing (0,0x03) then (2,0x40); in_ready stays 1.
- MUL, rd=7, am=0, alu_out=0xFE40, with in_valid held high carrying an ADD -> rf writes (7,0x40) then (0,0xFE); in_ready=0 for one cycle; the ADD write follows immediately.
- BEQZ, target=4: with zero_flag=0 -> no pc_load and no flush. With zero_flag=1 -> pc_load=1, flush=1, pc_target=4 for one cycle. Repeat for BPAR with parity_flag and target=5.
- HALT -> halted=1 and in_ready=0; subsequent valid ADDs produce no strobes. rst -> halted=0, in_ready=1.
- MUL accepted, then rst asserted in the MUL_HI cycle -> no high-half write; all outputs return to reset values.
